// File: rtl/program_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer_if
// Purpose  : Bundle of ROM, fetch-stage and datapath control signals around
//            the program sequencer. The master modport is the sequencer side.
//            rom_ready exists only when PROGRAM_SEQ_WAIT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface program_sequencer_if #(
  parameter int PC_WIDTH = 12
);
  logic [PC_WIDTH-1:0] rom_addr;
  logic [7:0]          rom_data;
`ifdef PROGRAM_SEQ_WAIT_EN
  logic                rom_ready;
`endif
  logic                load;
  logic [PC_WIDTH-1:0] load_addr;
  logic                hold;
  logic                phase;
  logic [PC_WIDTH-1:0] pc;
  logic [7:0]          programByte;
  logic                fetch_done;

`ifdef PROGRAM_SEQ_WAIT_EN
  modport master (
    output rom_addr, phase, pc, programByte, fetch_done,
    input  rom_data, rom_ready, load, load_addr, hold
  );
  modport slave (
    input  rom_addr, phase, pc, programByte, fetch_done,
    output rom_data, rom_ready, load, load_addr, hold
  );
`else
  modport master (
    output rom_addr, phase, pc, programByte, fetch_done,
    input  rom_data, load, load_addr, hold
  );
  modport slave (
    input  rom_addr, phase, pc, programByte, fetch_done,
    output rom_data, load, load_addr, hold
  );
`endif
endinterface
`default_nettype wire

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer
// Purpose  : Owns the program counter, generates the two-phase fetch/execute
//            signal, reads the program ROM and holds the registered
//            instruction byte for the fetch stage.
//            Optional ROM wait states: define PROGRAM_SEQ_WAIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module program_sequencer #(
  parameter int                   PC_WIDTH   = 12,
  parameter logic [PC_WIDTH-1:0]  RESET_ADDR = '0
) (
  input  wire logic                clk,
  input  wire logic                reset,
  program_sequencer_if.master      bus
);

  localparam logic [0:0] c_fetch = 1'b0;
  localparam logic [0:0] c_exec  = 1'b1;

  logic [0:0]          r_phase;
  logic [PC_WIDTH-1:0] r_pc;
  logic [7:0]          r_program_byte;
  logic                r_fetch_done;
  logic                w_rom_ready;

`ifdef PROGRAM_SEQ_WAIT_EN
  assign w_rom_ready = bus.rom_ready;
`else
  // Without wait states the ROM is assumed settled on every FETCH edge.
  assign w_rom_ready = 1'b1;
`endif

  // Sequencer state: reset beats hold, hold beats ROM wait, then sequencing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase        <= c_fetch;
      r_pc           <= RESET_ADDR;
      r_program_byte <= 8'h00;
      r_fetch_done   <= 1'b0;
    end else if (bus.hold) begin
      r_fetch_done   <= 1'b0;
    end else begin
      case (r_phase)
        c_fetch: begin
          if (w_rom_ready) begin
            r_program_byte <= bus.rom_data;
            r_phase        <= c_exec;
            r_fetch_done   <= 1'b1;
          end else begin
            r_fetch_done   <= 1'b0;
          end
        end
        default: begin
          // load is only honoured here; a FETCH-cycle pulse never reaches pc.
          r_pc         <= bus.load ? bus.load_addr : r_pc + 1'b1;
          r_phase      <= c_fetch;
          r_fetch_done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rom_addr    = r_pc;
  assign bus.pc          = r_pc;
  assign bus.phase       = r_phase[0];
  assign bus.programByte = r_program_byte;
  assign bus.fetch_done  = r_fetch_done;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_sequencer
// Purpose  : Directed self-checking bench for program_sequencer with a
//            behavioural asynchronous-read ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_sequencer;

  logic clk;
  logic reset;
  logic mode;   // 0: ROM returns 8'hCC everywhere, 1: ROM returns addr ^ 8'hF0
  int   checks;
  int   failures;

  program_sequencer_if #(.PC_WIDTH(12)) bus ();

  program_sequencer #(.PC_WIDTH(12), .RESET_ADDR(12'h000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rom_data = mode ? (bus.rom_addr[7:0] ^ 8'hF0) : 8'hCC;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic ph, input logic [11:0] pc,
                             input logic [7:0] pb, input logic fd);
    check({tag, ".phase"}, 16'(bus.phase), 16'(ph));
    check({tag, ".pc"}, 16'(bus.pc), 16'(pc));
    check({tag, ".rom_addr"}, 16'(bus.rom_addr), 16'(pc));
    check({tag, ".programByte"}, 16'(bus.programByte), 16'(pb));
    check({tag, ".fetch_done"}, 16'(bus.fetch_done), 16'(fd));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    mode      = 1'b0;
    reset     = 1'b1;
    bus.load      = 1'b0;
    bus.load_addr = 12'h000;
    bus.hold      = 1'b0;
`ifdef PROGRAM_SEQ_WAIT_EN
    bus.rom_ready = 1'b1;
`endif

    // Asynchronous reset before any clock edge
    #2 reset = 1'b0;
    #1 check_state("reset", 1'b0, 12'h000, 8'h00, 1'b0);
    #5 reset = 1'b1;

    // First instruction after release, ROM returns CC
    tick();
    check_state("first_fetch", 1'b1, 12'h000, 8'hCC, 1'b1);
    tick();
    check_state("first_exec", 1'b0, 12'h001, 8'hCC, 1'b0);

    // Free run over 4 instructions with addr ^ F0
    reset = 1'b0;
    #2;
    mode  = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_state($sformatf("run_fetch%0d", i), 1'b1, 12'(i), 8'hF0 + 8'(i), 1'b1);
      tick();
      check_state($sformatf("run_exec%0d", i), 1'b0, 12'(i + 1), 8'hF0 + 8'(i), 1'b0);
    end

    // load during FETCH is ignored
    bus.load      = 1'b1;
    bus.load_addr = 12'h3A5;
    tick();
    bus.load = 1'b0;
    tick();
    check_state("load_in_fetch", 1'b0, 12'h005, 8'hF4, 1'b0);

    // load during EXEC jumps
    tick();
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check_state("load_in_exec", 1'b0, 12'h3A5, 8'hF5, 1'b0);

    // hold for 3 cycles mid-FETCH
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_state($sformatf("hold_fetch%0d", i), 1'b0, 12'h3A5, 8'hF5, 1'b0);
    end
    bus.hold = 1'b0;
    tick();
    check_state("hold_resume", 1'b1, 12'h3A5, 8'h55, 1'b1);

    // hold in EXEC clears fetch_done and ignores load
    bus.hold = 1'b1;
    bus.load = 1'b1;
    bus.load_addr = 12'h123;
    tick();
    check_state("hold_exec", 1'b1, 12'h3A5, 8'h55, 1'b0);
    bus.hold = 1'b0;
    bus.load = 1'b0;
    tick();
    check_state("hold_exec_resume", 1'b0, 12'h3A6, 8'h55, 1'b0);

    // Jump to FFF then wrap to 000
    tick();
    bus.load = 1'b1;
    bus.load_addr = 12'hFFF;
    tick();
    bus.load = 1'b0;
    check("jump_fff.pc", 16'(bus.pc), 16'h0FFF);
    tick();
    check("wrap_fetch.programByte", 16'(bus.programByte), 16'h000F);
    tick();
    check_state("wrap", 1'b0, 12'h000, 8'h0F, 1'b0);

    // Reset mid-EXEC acts without a clock edge
    tick();
    tick();
    tick();
    check_state("pre_reset_exec", 1'b1, 12'h001, 8'hF1, 1'b1);
    #2 reset = 1'b0;
    #1 check_state("async_reset", 1'b0, 12'h000, 8'h00, 1'b0);
    #2 reset = 1'b1;
    tick();
    check_state("post_reset_fetch", 1'b1, 12'h000, 8'hF0, 1'b1);
    tick();

`ifdef PROGRAM_SEQ_WAIT_EN
    // Two wait states then load on rom_ready
    bus.rom_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_state($sformatf("wait%0d", i), 1'b0, 12'h001, 8'hF0, 1'b0);
    end
    bus.rom_ready = 1'b1;
    tick();
    check_state("wait_done", 1'b1, 12'h001, 8'hF1, 1'b1);
    tick();
    check_state("wait_exec", 1'b0, 12'h002, 8'hF1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_sequencer.md
# program_sequencer

Program-side counterpart of the Nibbler fetch stage: owns the program counter, generates the two-phase `phase` signal, reads the program ROM, and delivers a registered `programByte` that the fetch stage splits into instruction and operand nibbles. It sits between the program ROM and the fetch stage. The datapath feeds it jump requests (`load`/`load_addr`) and stall requests (`hold`).

## Interface
- `PC_WIDTH`, 12: program counter and ROM address width.
- `RESET_ADDR`, 0: PC value after reset.
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rom_addr`  out  PC_WIDTH  ROM address; combinationally equal to `pc`.
- `rom_data`  in  8  ROM read data, asynchronous-read ROM.
- `rom_ready`  in  1  ROM data valid. Present only when `PROGRAM_SEQ_WAIT_EN` is defined.
- `load`  in  1  jump request, sampled on execute-phase edges only.
- `load_addr`  in  PC_WIDTH  jump target.
- `hold`  in  1  stall; freezes all sequencer state.
- `phase`  out  1  0 = fetch, 1 = execute; drives the fetch stage phase input.
- `pc`  out  PC_WIDTH  current program counter.
- `programByte`  out  8  registered instruction byte, stable across the whole instruction.
- `fetch_done`  out  1  one-cycle pulse in the cycle after `programByte` updates.

## Operation
- Two-state FSM on `phase`: FETCH (0) and EXEC (1).
- FETCH edge (`hold`=0, ROM ready):
  - `programByte` <= `rom_data`.
  - `phase` <= 1.
  - `fetch_done` <= 1.
- EXEC edge (`hold`=0):
  - `pc` <= `load` ? `load_addr` : `pc`+1, modulo 2^PC_WIDTH.
  - `phase` <= 0.
  - `fetch_done` <= 0.
- `hold`=1: `phase`, `pc` and `programByte` keep their values; `fetch_done` <= 0; `load` is ignored.
- Wrap-around: `pc` = all-ones with no load goes to 0. No flag is raised.
- `load` asserted during FETCH is ignored, even if it is still high at the next EXEC edge only that EXEC-edge sample matters.
- Priority on every edge: `reset` > `hold` > ROM wait > normal sequencing.

## Timing
- Reset (`reset`=0, asynchronous):
  - `phase`=0, `pc`=RESET_ADDR, `rom_addr`=RESET_ADDR.
  - `programByte`=8'h00, `fetch_done`=0.
- Reset asserted mid-instruction discards the partial instruction immediately. After release, the first edge is a FETCH of RESET_ADDR.
- Nominal instruction period is 2 cycles: FETCH then EXEC.
- Address-to-`programByte` latency is 1 edge.
- `programByte` is constant from the FETCH edge until the next FETCH edge.
- `rom_addr` changes only on EXEC edges, so the ROM has one full cycle to settle before the FETCH edge samples it.
- `fetch_done` is high exactly during the EXEC cycle that follows an update.

## Configuration
- `PROGRAM_SEQ_WAIT_EN` defined:
  - Adds the `rom_ready` port.
  - A FETCH edge with `rom_ready`=0 is a wait state: `phase` stays 0, `programByte` is unchanged, `fetch_done`=0.
  - Any number of wait states are allowed.
  - `hold` still takes precedence over `rom_ready`.
- `PROGRAM_SEQ_WAIT_EN` undefined:
  - No `rom_ready` port.
  - The ROM is ready on every FETCH edge and the instruction period is fixed at 2 cycles.

## Test plan
- Reset release, ROM returns `rom_data`=8'hCC at address 0 -> after 1 edge `programByte`=8'hCC, `phase`=1, `fetch_done`=1; after the next edge `pc`=1, `phase`=0.
- Free run over 4 instructions with ROM returning `addr` XOR 8'hF0 -> `programByte` sequence 8'hF0, 8'hF1, 8'hF2, 8'hF3, each held for 2 cycles; `pc` sequence 0, 1, 2, 3, 4.
- `load`=1 with `load_addr`=12'h3A5 during EXEC -> next `rom_addr`=12'h3A5. The same pulse applied during FETCH -> ignored, `pc` increments normally.
- `hold`=1 for 3 cycles mid-FETCH -> `phase`, `pc` and `programByte` frozen, `fetch_done`=0; sequencing resumes on the first edge with `hold`=0.
- `pc`=12'hFFF, no load, EXEC edge -> `pc`=12'h000. `reset` pulsed low mid-EXEC -> `pc`=RESET_ADDR and `programByte`=8'h00 immediately, without waiting for a clock edge.
- With `PROGRAM_SEQ_WAIT_EN` defined and `rom_ready` low for 2 FETCH edges -> 2 wait cycles, then `programByte` loads on the `rom_ready`=1 edge; instruction period is 4 cycles.
